// File: rtl/hack_memory_map_pkg.sv
// rtl/hack_memory_map_pkg.sv - region codes, keyboard page offsets and status bits for hack_memory_map
package hack_mem_pkg;

    // Region select carried in the top two address bits
    typedef enum logic [1:0] {
        REG_RAM0 = 2'b00,
        REG_RAM1 = 2'b01,
        REG_SCR  = 2'b10,
        REG_KBD  = 2'b11
    } region_e;

    // Word offsets inside the keyboard page
    localparam int KBD_DATA_OFF = 0;
    localparam int KBD_STAT_OFF = 1;

    // Bit positions in the KBD_STAT word
    localparam int STAT_NE  = 0;
    localparam int STAT_OVF = 1;

endpackage

// File: rtl/hack_memory_map_kbd_fifo.sv
// rtl/hack_memory_map_kbd_fifo.sv - keyboard code FIFO with wrap-around pointers and occupancy count
module kbd_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO or a pop from an empty one is simply dropped
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Entry storage; not reset, since empty masks stale contents
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and count; reset discards everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hack_memory_map.sv
// rtl/hack_memory_map.sv - Hack data memory map: RAM, screen and keyboard FIFO page (option: HACK_MEM_SCR_TAP_EN)
module hack_memory_map
    import hack_mem_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 15,
    parameter int KBD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out,
    input  logic [DATA_W-1:0] kbd_code,
    input  logic              kbd_valid,
    output logic              kbd_ready
`ifdef HACK_MEM_SCR_TAP_EN
    ,
    output logic              scr_wr_valid,
    output logic [ADDR_W-3:0] scr_wr_addr,
    output logic [DATA_W-1:0] scr_wr_data
`endif
);

    // Regions 00 and 01 together form one RAM; screen and keyboard each take a quarter
    localparam int RAM_AW = ADDR_W - 1;
    localparam int SCR_AW = ADDR_W - 2;

    logic [DATA_W-1:0] ram [2**RAM_AW];
    logic [DATA_W-1:0] scr [2**SCR_AW];

    region_e           region;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_idx;
    logic              is_ram;
    logic              is_scr;
    logic              kbd_data_sel;
    logic              kbd_stat_sel;

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              ovf;
    logic [DATA_W-1:0] stat_word;

    assign region       = region_e'(address[ADDR_W-1:ADDR_W-2]);
    assign ram_idx      = address[RAM_AW-1:0];
    assign scr_idx      = address[SCR_AW-1:0];
    assign is_ram       = (region == REG_RAM0) || (region == REG_RAM1);
    assign is_scr       = (region == REG_SCR);
    assign kbd_data_sel = (region == REG_KBD) && (scr_idx == SCR_AW'(KBD_DATA_OFF));
    assign kbd_stat_sel = (region == REG_KBD) && (scr_idx == SCR_AW'(KBD_STAT_OFF));

    // Ready reflects only the registered occupancy, never the CPU side
    assign kbd_ready = !fifo_full;
    assign fifo_push = kbd_valid && !fifo_full;
    assign fifo_pop  = load && kbd_data_sel;

    kbd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (kbd_code),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // General RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (load && is_ram) begin
            ram[ram_idx] <= in;
        end
    end

    // Screen RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (load && is_scr) begin
            scr[scr_idx] <= in;
        end
    end

    // Sticky overflow: a dropped code outranks a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (kbd_valid && fifo_full) begin
            ovf <= 1'b1;
        end else if (load && kbd_stat_sel) begin
            ovf <= 1'b0;
        end
    end

    // Status word assembly
    always_comb begin
        stat_word           = '0;
        stat_word[STAT_NE]  = !fifo_empty;
        stat_word[STAT_OVF] = ovf;
    end

    // Combinational read mux; unmapped keyboard offsets read zero
    always_comb begin
        out = '0;
        unique case (region)
            REG_RAM0, REG_RAM1: out = ram[ram_idx];
            REG_SCR:            out = scr[scr_idx];
            REG_KBD: begin
                if (kbd_data_sel && !fifo_empty) begin
                    out = fifo_head;
                end else if (kbd_stat_sel) begin
                    out = stat_word;
                end
            end
            default:            out = '0;
        endcase
    end

`ifdef HACK_MEM_SCR_TAP_EN
    // One-cycle echo of each screen write for the display controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_wr_valid <= 1'b0;
            scr_wr_addr  <= '0;
            scr_wr_data  <= '0;
        end else begin
            scr_wr_valid <= load && is_scr;
            if (load && is_scr) begin
                scr_wr_addr <= scr_idx;
                scr_wr_data <= in;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hack_memory_map.sv
// tb/tb_hack_memory_map.sv - scoreboard bench for hack_memory_map
module tb_hack_memory_map;

    localparam int K_OUT = 0;
    localparam int K_RDY = 1;
    localparam int K_TV  = 2;
    localparam int K_TA  = 3;
    localparam int K_TD  = 4;

    typedef struct {
        int          kind;
        string       name;
        logic [15:0] exp;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in = '0;
    logic        load = 1'b0;
    logic [14:0] address = '0;
    logic [15:0] out;
    logic [15:0] kbd_code = '0;
    logic        kbd_valid = 1'b0;
    logic        kbd_ready;
`ifdef HACK_MEM_SCR_TAP_EN
    logic        scr_wr_valid;
    logic [12:0] scr_wr_addr;
    logic [15:0] scr_wr_data;
`endif

    sb_t sb[$];
    logic chk_valid = 1'b0;
    logic finish_req = 1'b0;
    logic done = 1'b0;
    int   total = 0;
    int   bad = 0;

    hack_memory_map dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .load      (load),
        .address   (address),
        .out       (out),
        .kbd_code  (kbd_code),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready)
`ifdef HACK_MEM_SCR_TAP_EN
        ,
        .scr_wr_valid (scr_wr_valid),
        .scr_wr_addr  (scr_wr_addr),
        .scr_wr_data  (scr_wr_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // Monitor: on each falling edge where stimulus flags a check, pop and compare
    always @(negedge clk) begin
        logic [15:0] act;
        sb_t e;
        if (chk_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: check strobe with no expected entry");
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                act = '0;
                case (e.kind)
                    K_OUT: act = out;
                    K_RDY: act = {15'b0, kbd_ready};
`ifdef HACK_MEM_SCR_TAP_EN
                    K_TV:  act = {15'b0, scr_wr_valid};
                    K_TA:  act = {3'b0, scr_wr_addr};
                    K_TD:  act = scr_wr_data;
`endif
                    default: act = 16'hxxxx;
                endcase
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, act, e.exp);
                end
            end
        end
        if (finish_req && !done) begin
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL sb_drain: %0d entries never checked", sb.size());
            end
            done <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int kind, input string name, input logic [15:0] v);
        sb_t e;
        e.kind = kind;
        e.name = name;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic go();
        chk_valid = 1'b1;
        tick();
        chk_valid = 1'b0;
    endtask

    task automatic rd(input logic [14:0] a, input logic [15:0] v, input string name);
        address = a;
        expect_val(K_OUT, name, v);
        go();
    endtask

    task automatic rdy(input logic v, input string name);
        expect_val(K_RDY, name, {15'b0, v});
        go();
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        address = a;
        in = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic kpush(input logic [15:0] c);
        kbd_code = c;
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
    endtask

    // Same-cycle keyboard push together with a CPU write to the given page offset
    task automatic push_and_write(input logic [15:0] c, input logic [14:0] a);
        kbd_code = c;
        kbd_valid = 1'b1;
        address = a;
        load = 1'b1;
        tick();
        kbd_valid = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        // Values while held in reset
        rdy(1'b1, "rst_ready");
        rd(15'h6000, 16'h0000, "rst_kdata");
        rd(15'h6001, 16'h0000, "rst_kstat");
        rst_n = 1'b1;
        tick();

        // RAM and screen
        wr(15'h0005, 16'h1234);
        wr(15'h4005, 16'hBEEF);
        wr(15'h4000, 16'hA5A5);
        wr(15'h2005, 16'h5555);
        rd(15'h0005, 16'h1234, "ram_5");
        rd(15'h4005, 16'hBEEF, "scr_5");
        rd(15'h4000, 16'hA5A5, "scr_base");
        rd(15'h2005, 16'h5555, "ram_2005");
        address = 15'h0005;
        in = 16'h9999;
        load = 1'b1;
        expect_val(K_OUT, "raw_old_data", 16'h1234);
        go();
        load = 1'b0;
        rd(15'h0005, 16'h9999, "raw_new_data");
        rd(15'h6002, 16'h0000, "kbd_other_off");

        // Basic keyboard FIFO
        kpush(16'h0041);
        kpush(16'h0042);
        rd(15'h6001, 16'h0001, "k2_stat");
        rd(15'h6000, 16'h0041, "k2_head0");
        wr(15'h6000, 16'h0000);
        rd(15'h6000, 16'h0042, "k2_head1");
        wr(15'h6000, 16'hFFFF);
        rd(15'h6000, 16'h0000, "k2_empty_data");
        rd(15'h6001, 16'h0000, "k2_empty_stat");
        wr(15'h6000, 16'h0000);
        rd(15'h6001, 16'h0000, "pop_empty_stat");

        // Overfill: fifth code dropped, overflow set
        for (int i = 0; i < 4; i++) kpush(16'h0010 + 16'(i));
        rdy(1'b0, "full_ready");
        kpush(16'h0014);
        rd(15'h6001, 16'h0003, "ovf_stat");
        for (int i = 0; i < 4; i++) begin
            rd(15'h6000, 16'h0010 + 16'(i), "drain_head");
            wr(15'h6000, 16'h0000);
        end
        rd(15'h6001, 16'h0002, "drained_ovf_stat");
        rdy(1'b1, "drained_ready");
        wr(15'h6001, 16'h0000);
        rd(15'h6001, 16'h0000, "ovf_cleared");

        // Full with same-cycle pop: push still dropped, count goes to 3
        for (int i = 0; i < 4; i++) kpush(16'h0020 + 16'(i));
        push_and_write(16'h0099, 15'h6000);
        rd(15'h6001, 16'h0003, "fullpop_stat");
        rd(15'h6000, 16'h0021, "fullpop_head");
        rdy(1'b1, "fullpop_ready");
        kpush(16'h0030);
        rdy(1'b0, "refull_ready");
        // Set and clear together: set wins
        push_and_write(16'h0077, 15'h6001);
        rd(15'h6001, 16'h0003, "set_wins_stat");
        rd(15'h6000, 16'h0021, "fq0");
        wr(15'h6000, 16'h0000);
        rd(15'h6000, 16'h0022, "fq1");
        wr(15'h6000, 16'h0000);
        rd(15'h6000, 16'h0023, "fq2");
        wr(15'h6000, 16'h0000);
        rd(15'h6000, 16'h0030, "fq3");
        wr(15'h6000, 16'h0000);
        rd(15'h6001, 16'h0002, "fq_empty_stat");
        wr(15'h6001, 16'h0000);

        // Non-full push plus pop in one cycle
        kpush(16'h0050);
        kpush(16'h0051);
        push_and_write(16'h0052, 15'h6000);
        rd(15'h6000, 16'h0051, "pp_head");
        wr(15'h6000, 16'h0000);
        rd(15'h6000, 16'h0052, "pp_head2");
        wr(15'h6000, 16'h0000);
        rd(15'h6001, 16'h0000, "pp_stat");

        // Asynchronous reset mid-cycle
        wr(15'h0007, 16'h7777);
        kpush(16'h0060);
        kpush(16'h0061);
        rd(15'h6001, 16'h0001, "pre_rst_stat");
        rst_n = 1'b0;
        address = 15'h6001;
        expect_val(K_OUT, "async_rst_stat", 16'h0000);
        expect_val(K_RDY, "async_rst_ready", 16'h0001);
        go();
        rst_n = 1'b1;
        tick();
        rd(15'h0007, 16'h7777, "ram_survives_rst");
        rd(15'h4000, 16'hA5A5, "scr_survives_rst");

`ifdef HACK_MEM_SCR_TAP_EN
        wr(15'h4010, 16'h00FF);
        expect_val(K_TV, "tap_valid", 16'h0001);
        expect_val(K_TA, "tap_addr", 16'h0010);
        expect_val(K_TD, "tap_data", 16'h00FF);
        go();
        expect_val(K_TV, "tap_one_cycle", 16'h0000);
        go();
        wr(15'h0010, 16'h1111);
        expect_val(K_TV, "tap_ram_quiet", 16'h0000);
        go();
`endif

        finish_req = 1'b1;
        for (int i = 0; i < 10 && !done; i++) tick();
        if (!done) begin
            $display("FAIL drain_timeout: monitor did not finish");
            $display("test done: total=%0d bad=%0d", total, bad + 1);
        end else begin
            $display("test done: total=%0d bad=%0d", total, bad);
        end
        $finish;
    end

endmodule
